stopwatch_ctrl: RTL and testbench

// - Control FSM for the intro-II stopwatch. Takes the four raw push-buttons and

---
 rtl/stopwatch_ctrl.sv | 176 +++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button debounce, count-tick prescaler and run/pause/lap sequencing.
// Define STOPWATCH_LAP_EN to build the lap feature (LAP state, lap_latch, disp_hold).

module stopwatch_db #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] stable_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level      <= 1'b0;
      level_d    <= 1'b0;
      stable_cnt <= '0;
      press      <= 1'b0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      // any sample equal to the current level restarts the stability count
      if (sync2 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CW'(DB_CYCLES - 1)) begin
        level      <= sync2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + CW'(1);
      end
    end
  end
endmodule

// state | meaning
// IDLE  | stopped, time cleared (or clearable)
// RUN   | counting, display shows live time
// PAUSE | stopped, time held
// LAP   | counting, display frozen on lap register
module stopwatch_ctrl #(
  parameter int TICK_DIV  = 100000,
  parameter int DB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic       cnt_max,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       lap_latch,
  output logic       disp_hold,
  output logic [1:0] state
);
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_LAP   = 2'b11;
  localparam int         PW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic          p_start;
  logic          p_lap;
  logic          p_clr;
  logic [1:0]    state_nxt;
  logic [PW-1:0] presc;
  logic          tick;
  logic          counting;
  logic          counting_nxt;
  logic          cnt_en_nxt;
  logic          cnt_clr_nxt;
  logic          unused_btn;

  stopwatch_db #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk(clk), .rst(rst), .btn_raw(btn[0]), .press(p_start)
  );
  stopwatch_db #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk(clk), .rst(rst), .btn_raw(btn[2]), .press(p_clr)
  );

`ifdef STOPWATCH_LAP_EN
  stopwatch_db #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
    .clk(clk), .rst(rst), .btn_raw(btn[1]), .press(p_lap)
  );
  assign unused_btn = btn[3];
`else
  assign p_lap      = 1'b0;
  assign unused_btn = ^{btn[3], btn[1]};
`endif

  assign tick         = (presc == PW'(TICK_DIV - 1));
  assign counting     = (state == S_RUN) || (state == S_LAP);
  assign counting_nxt = (state_nxt == S_RUN) || (state_nxt == S_LAP);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // press priority clear > start > lap; illegal presses fall through
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (p_clr)        state_nxt = S_IDLE;
        else if (p_start) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (p_start)               state_nxt = S_PAUSE;
        else if (p_lap)            state_nxt = S_LAP;
        else if (tick && cnt_max)  state_nxt = S_PAUSE;
      end
      S_LAP: begin
        if (p_start)               state_nxt = S_PAUSE;
        else if (p_lap)            state_nxt = S_RUN;
        else if (tick && cnt_max)  state_nxt = S_PAUSE;
      end
      S_PAUSE: begin
        if (p_clr)        state_nxt = S_IDLE;
        else if (p_start) state_nxt = S_RUN;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // a tick landing on a transition cycle is dropped
  always_comb begin
    cnt_en_nxt  = tick && counting && !cnt_max && (state_nxt == state);
    cnt_clr_nxt = p_clr && ((state == S_IDLE) || (state == S_PAUSE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc   <= '0;
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
    end else begin
      if (counting && counting_nxt) presc <= tick ? '0 : presc + PW'(1);
      else                          presc <= '0;
      cnt_en  <= cnt_en_nxt;
      cnt_clr <= cnt_clr_nxt;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic lap_latch_nxt;
  logic disp_hold_nxt;

  always_comb begin
    lap_latch_nxt = (state == S_RUN) && (state_nxt == S_LAP);
    disp_hold_nxt = (state_nxt == S_LAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lap_latch <= 1'b0;
      disp_hold <= 1'b0;
    end else begin
      lap_latch <= lap_latch_nxt;
      disp_hold <= disp_hold_nxt;
    end
  end
`else
  assign lap_latch = 1'b0;
  assign disp_hold = 1'b0;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4, DB_CYCLES=2.
// Lap checks follow STOPWATCH_LAP_EN; otherwise btn[1] must have no effect.
module tb_stopwatch_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic       cnt_max;
  logic       cnt_en;
  logic       cnt_clr;
  logic       lap_latch;
  logic       disp_hold;
  logic [1:0] state;

  int vectors     = 0;
  int miscompares = 0;

  stopwatch_ctrl #(.TICK_DIV(4), .DB_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .btn(btn), .cnt_max(cnt_max),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr), .lap_latch(lap_latch),
    .disp_hold(disp_hold), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_count(input int n, output int en, output int clr, output int lat);
    en = 0; clr = 0; lat = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      en  += int'(cnt_en);
      clr += int'(cnt_clr);
      lat += int'(lap_latch);
    end
  endtask

  task automatic first_en(input int budget, output int d);
    d = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      if (cnt_en === 1'b1) begin
        d = i;
        break;
      end
    end
  endtask

  initial begin
    int d, en, clr, lat;
    rst = 1'b1; btn = 4'b0000; cnt_max = 1'b0;
    step(3);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cnt_en", 32'(cnt_en), 32'd0);
    chk("rst_cnt_clr", 32'(cnt_clr), 32'd0);
    chk("rst_lap_latch", 32'(lap_latch), 32'd0);
    chk("rst_disp_hold", 32'(disp_hold), 32'd0);
    rst = 1'b0;
    step(2);

    // start latency: first sampled at edge k, state RUN after k+5
    btn = 4'b0001;
    step(5);
    chk("start_early", 32'(state), 32'd0);
    step(1);
    chk("start_run", 32'(state), 32'd1);
    first_en(20, d);
    chk("first_en_delay", d, 32'd4);
    first_en(20, d);
    chk("en_period", d, 32'd4);
    btn = 4'b0000;
    step(8);

    // reset mid-RUN
    rst = 1'b1;
    step(2);
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_outs", 32'({cnt_en, cnt_clr, lap_latch, disp_hold}), 32'd0);
    rst = 1'b0;
    run_count(6, en, clr, lat);
    chk("postrst_no_en", en, 32'd0);
    btn = 4'b0001;
    step(6);
    chk("restart_run", 32'(state), 32'd1);
    first_en(20, d);
    chk("restart_en_delay", d, 32'd4);
    btn = 4'b0000;
    step(8);

    // bounce: 10 toggles then steady high -> one start event 5 cycles later
    for (int i = 0; i < 10; i++) begin
      btn[0] = ~btn[0];
      step(1);
    end
    chk("bounce_no_event", 32'(state), 32'd1);
    btn[0] = 1'b1;
    step(5);
    chk("bounce_early", 32'(state), 32'd1);
    step(1);
    chk("bounce_event", 32'(state), 32'd2);
    step(10);
    chk("held_one_press", 32'(state), 32'd2);
    btn = 4'b0000;
    step(8);
    chk("release_no_event", 32'(state), 32'd2);

    // PAUSE: start+clear together -> clear wins
    btn = 4'b0101;
    step(6);
    chk("pause_sim_state", 32'(state), 32'd0);
    chk("pause_sim_clr", 32'(cnt_clr), 32'd1);
    run_count(10, en, clr, lat);
    chk("pause_sim_one_clr", clr, 32'd0);
    chk("pause_sim_no_run", 32'(state), 32'd0);
    btn = 4'b0000;
    step(8);

    // RUN: start+clear together -> start honoured, clear dropped
    btn = 4'b0001;
    step(6);
    chk("to_run", 32'(state), 32'd1);
    btn = 4'b0000;
    step(8);
    btn = 4'b0101;
    run_count(6, en, clr, lat);
    chk("run_sim_state", 32'(state), 32'd2);
    chk("run_sim_no_clr", clr, 32'd0);
    btn = 4'b0000;
    step(8);

    // overflow: cnt_max in RUN -> next tick gives no cnt_en, goes PAUSE
    btn = 4'b0001;
    step(6);
    chk("ovf_run", 32'(state), 32'd1);
    cnt_max = 1'b1;
    run_count(3, en, clr, lat);
    chk("ovf_pre_state", 32'(state), 32'd1);
    chk("ovf_pre_en", en, 32'd0);
    step(1);
    chk("ovf_state", 32'(state), 32'd2);
    chk("ovf_no_en", 32'(cnt_en), 32'd0);
    btn = 4'b0000;
    step(8);
    chk("ovf_stays_pause", 32'(state), 32'd2);
    btn = 4'b0100;
    step(6);
    chk("ovf_clr_pulse", 32'(cnt_clr), 32'd1);
    chk("ovf_clr_state", 32'(state), 32'd0);
    cnt_max = 1'b0;
    btn = 4'b0000;
    step(8);

    btn = 4'b0001;
    step(6);
    chk("lap_pre_run", 32'(state), 32'd1);
    btn = 4'b0000;
    step(8);
`ifdef STOPWATCH_LAP_EN
    btn = 4'b0010;
    step(6);
    chk("lap_state", 32'(state), 32'd3);
    chk("lap_latch_pulse", 32'(lap_latch), 32'd1);
    chk("lap_hold", 32'(disp_hold), 32'd1);
    run_count(8, en, clr, lat);
    chk("lap_en_continues", en, 32'd2);
    chk("lap_single_latch", lat, 32'd0);
    chk("lap_hold_stays", 32'(disp_hold), 32'd1);
    btn = 4'b0000;
    step(8);
    btn = 4'b0010;
    run_count(6, en, clr, lat);
    chk("lap_back_state", 32'(state), 32'd1);
    chk("lap_back_hold", 32'(disp_hold), 32'd0);
    chk("lap_back_no_latch", lat, 32'd0);
    btn = 4'b0000;
    step(8);
`else
    btn = 4'b0010;
    run_count(12, en, clr, lat);
    chk("nolap_state", 32'(state), 32'd1);
    chk("nolap_no_latch", lat, 32'd0);
    chk("nolap_no_hold", 32'(disp_hold), 32'd0);
    chk("nolap_en", en, 32'd3);
    chk("nolap_no_clr", clr, 32'd0);
    btn = 4'b0000;
    step(8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
